// File: rtl/pixel_pkg.sv
// Shared state encoding, default display window and width helper for the pixel unpacker.
package pixel_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_EMPTY = 2'd1;
    localparam state_t S_HAVE  = 2'd2;

    localparam int unsigned DEF_X_START = 192;
    localparam int unsigned DEF_X_END   = 448;
    localparam int unsigned DEF_Y_START = 48;
    localparam int unsigned DEF_Y_END   = 432;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = unsigned'(i + 1);
        end
        return result;
    endfunction

endpackage

// File: rtl/pixel_window_decode.sv
// Decodes the active display window and the first pixel of a frame from hcount/vcount.
module pixel_window_decode
    import pixel_pkg::*;
#(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned X_START = DEF_X_START,
    parameter int unsigned X_END   = DEF_X_END,
    parameter int unsigned Y_START = DEF_Y_START,
    parameter int unsigned Y_END   = DEF_Y_END
) (
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    output logic             in_win,
    output logic             frame_start
);

    assign in_win = (vcount >= CNT_W'(Y_START)) && (vcount < CNT_W'(Y_END)) &&
                    (hcount >= CNT_W'(X_START)) && (hcount < CNT_W'(X_END));

    assign frame_start = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/pixel_unpack_fsm.sv
// Unpacks FWFT FIFO words into one pixel per clock inside the display window.
// Optional horizontal pixel doubling is enabled by defining PIX_DOUBLE_EN.
module pixel_unpack_fsm
    import pixel_pkg::*;
#(
    parameter int unsigned WORD_W       = 16,
    parameter int unsigned PIX_W        = 3,
    parameter int unsigned PIX_PER_WORD = 5,
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned X_START      = DEF_X_START,
    parameter int unsigned X_END        = DEF_X_END,
    parameter int unsigned Y_START      = DEF_Y_START,
    parameter int unsigned Y_END        = DEF_Y_END
) (
    input  logic              clk_20MHz,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  hcount,
    input  logic [CNT_W-1:0]  vcount,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic [PIX_W-1:0]  pix_rgb,
    output logic              pix_valid,
    output logic              underflow,
    output logic [15:0]       word_cnt
);

    localparam int unsigned IDX_W = (clog2(PIX_PER_WORD) > 0) ? clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

    if (PIX_W * PIX_PER_WORD > WORD_W) begin : g_bad_packing
        $error("pixel_unpack_fsm: PIX_W*PIX_PER_WORD exceeds WORD_W");
    end

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  word_reg, word_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [PIX_W-1:0]   rgb_nxt;
    logic               valid_nxt, underflow_nxt;
    logic [15:0]        cnt_nxt;
    logic               in_win, frame_start, advance, pop;

    pixel_window_decode #(
        .CNT_W   (CNT_W),
        .X_START (X_START),
        .X_END   (X_END),
        .Y_START (Y_START),
        .Y_END   (Y_END)
    ) u_window (
        .hcount      (hcount),
        .vcount      (vcount),
        .in_win      (in_win),
        .frame_start (frame_start)
    );

`ifdef PIX_DOUBLE_EN
    logic phase, phase_eff;

    // The first window column of every line restarts the pair.
    assign phase_eff = (hcount == CNT_W'(X_START)) ? 1'b0 : phase;
    assign advance   = phase_eff;

    always_ff @(posedge clk_20MHz) begin
        if (reset || frame_start) phase <= 1'b0;
        else if (in_win)          phase <= ~phase_eff;
    end
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_nxt     = state;
        word_nxt      = word_reg;
        idx_nxt       = idx;
        rgb_nxt       = '0;
        valid_nxt     = 1'b0;
        underflow_nxt = underflow;
        cnt_nxt       = word_cnt;
        pop           = 1'b0;

        if (!enable) begin
            state_nxt = S_IDLE;
            word_nxt  = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_EMPTY;
                S_EMPTY: begin
                    underflow_nxt = underflow | in_win;
                    pop           = !fifo_empty;
                end
                S_HAVE: begin
                    if (frame_start && idx != '0) begin
                        // Drop the tail of a word left over from the previous frame.
                        idx_nxt   = '0;
                        state_nxt = S_EMPTY;
                        pop       = !fifo_empty;
                    end else if (in_win) begin
                        rgb_nxt   = word_reg[idx*PIX_W +: PIX_W];
                        valid_nxt = 1'b1;
                        if (advance) begin
                            if (idx != IDX_LAST) begin
                                idx_nxt = idx + 1'b1;
                            end else begin
                                idx_nxt = '0;
                                pop     = !fifo_empty;
                                if (fifo_empty) state_nxt = S_EMPTY;
                            end
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        if (pop) begin
            word_nxt  = fifo_dout;
            idx_nxt   = '0;
            state_nxt = S_HAVE;
        end

        if (frame_start) begin
            underflow_nxt = 1'b0;
            cnt_nxt       = {15'd0, pop};
        end else if (pop && word_cnt != 16'hFFFF) begin
            cnt_nxt = word_cnt + 16'd1;
        end
    end

    assign fifo_rd = pop && !reset;

    always_ff @(posedge clk_20MHz) begin
        if (reset) begin
            state     <= S_IDLE;
            word_reg  <= '0;
            idx       <= '0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            word_reg  <= word_nxt;
            idx       <= idx_nxt;
            pix_rgb   <= rgb_nxt;
            pix_valid <= valid_nxt;
            underflow <= underflow_nxt;
            word_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pixel_unpack_fsm.sv
// Self-checking bench for pixel_unpack_fsm with default parameters and a queue-based FIFO model.
module tb_pixel_unpack_fsm;

    logic        clk_20MHz = 1'b0;
    logic        reset, enable;
    logic [10:0] hcount, vcount;
    logic [15:0] fifo_dout;
    logic        fifo_empty, fifo_rd;
    logic [2:0]  pix_rgb;
    logic        pix_valid, underflow;
    logic [15:0] word_cnt;

    pixel_unpack_fsm dut (
        .clk_20MHz  (clk_20MHz),
        .reset      (reset),
        .enable     (enable),
        .hcount     (hcount),
        .vcount     (vcount),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .pix_rgb    (pix_rgb),
        .pix_valid  (pix_valid),
        .underflow  (underflow),
        .word_cnt   (word_cnt)
    );

    always #25 clk_20MHz = ~clk_20MHz;

    typedef struct packed {
        logic [2:0] rgb;
        logic       valid;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        push;
        logic [15:0] word;
        logic [2:0]  rgb;
        logic        valid;
        logic        rd;
        logic        under;
        logic [15:0] cnt;
    } vec_t;

    logic [15:0] fifo_q[$];
    exp_t        sb[$];
    vec_t        tbl[$];
    logic [15:0] words[0:119];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive counts and FIFO state, check the pop strobe, then score the output.
    task automatic cyc(input int h, input int v, input logic [2:0] e_rgb, input logic e_valid,
                       input int e_rd);
        exp_t got;
        logic rd;
        @(negedge clk_20MHz);
        hcount     = h[10:0];
        vcount     = v[10:0];
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 16'h0000 : fifo_q[0];
        sb.push_back({e_rgb, e_valid});
        #1;
        if (e_rd >= 0) check("fifo_rd", 32'(fifo_rd), 32'(e_rd));
        if (fifo_empty) check("rd_while_empty", 32'(fifo_rd), 32'd0);
        rd = fifo_rd;
        @(posedge clk_20MHz);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        got = sb.pop_front();
        check("pix_rgb", 32'(pix_rgb), 32'(got.rgb));
        check("pix_valid", 32'(pix_valid), 32'(got.valid));
    endtask

    task automatic add(input int h, input int v, input logic push, input logic [15:0] word,
                       input logic [2:0] rgb, input logic valid, input logic rd,
                       input logic under, input logic [15:0] cnt);
        tbl.push_back('{h, v, push, word, rgb, valid, rd, under, cnt});
    endtask

    initial begin
        logic [15:0] w;
        int          n;

        reset = 1'b1; enable = 1'b0; hcount = '0; vcount = '0;
        fifo_empty = 1'b1; fifo_dout = '0;

        // Reset held with data waiting: no pops, outputs cleared.
        fifo_q.push_back(16'hBEEF);
        enable = 1'b1;
        cyc(10, 0, 3'd0, 1'b0, 0);
        cyc(11, 0, 3'd0, 1'b0, 0);
        check("reset_underflow", 32'(underflow), 32'd0);
        check("reset_word_cnt", 32'(word_cnt), 32'd0);
        fifo_q.delete();

        // Prefetch, unpack 16'h4A3B and 16'h1234, underflow, refill, frame restart.
        add(100, 48, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        add(101, 48, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'd1);
        add(102, 48, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        add(192, 48, 1'b0, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 16'd1);
        add(193, 48, 1'b0, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 16'd1);
        add(194, 48, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'd1);
        add(195, 48, 1'b0, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 16'd1);
        add(196, 48, 1'b0, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 16'd2);
        add(197, 48, 1'b0, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 16'd2);
        add(198, 48, 1'b0, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 16'd2);
        add(448, 48, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd2);
        add(199, 48, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'd2);
        add(200, 48, 1'b0, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 16'd2);
        add(201, 48, 1'b0, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 16'd2);
        add(202, 48, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 16'd2);
        add(203, 48, 1'b1, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b1, 16'd3);
        add(204, 48, 1'b0, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b1, 16'd3);
        add(205, 48, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 16'd3);
        add(0,   0,  1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        reset = 1'b0;
        fifo_q.push_back(16'h4A3B);
        fifo_q.push_back(16'h1234);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) fifo_q.push_back(tbl[i].word);
            cyc(tbl[i].h, tbl[i].v, tbl[i].rgb, tbl[i].valid, 32'(tbl[i].rd));
            check("underflow", 32'(underflow), 32'(tbl[i].under));
            check("word_cnt", 32'(word_cnt), 32'(tbl[i].cnt));
        end

        // Two full window lines from a continuously fed FIFO.
        for (int i = 0; i < 120; i++) begin
            words[i] = 16'($urandom);
            fifo_q.push_back(words[i]);
        end
        cyc(10, 0, 3'd0, 1'b0, 1);
        n = 0;
        for (int v = 48; v < 50; v++) begin
            for (int h = 192; h < 448; h++) begin
                w = words[n / 5] >> (3 * (n % 5));
                cyc(h, v, w[2:0], 1'b1, -1);
                n++;
            end
            cyc(448, v, 3'd0, 1'b0, 0);
            cyc(449, v, 3'd0, 1'b0, 0);
        end
        check("stream_word_cnt", 32'(word_cnt), 32'd103);
        check("stream_underflow", 32'(underflow), 32'd0);

        // Frame start mid-word: remainder of word 102 dropped, word 103 fetched.
        cyc(0, 0, 3'd0, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            w = words[103] >> (3 * k);
            cyc(192 + k, 48, w[2:0], 1'b1, (k == 4) ? 1 : 0);
        end

        // Enable drop discards the held word (104); the next pixel comes from word 105.
        enable = 1'b0;
        cyc(197, 48, 3'd0, 1'b0, 0);
        enable = 1'b1;
        cyc(198, 48, 3'd0, 1'b0, 0);
        cyc(199, 48, 3'd0, 1'b0, 1);
        check("underflow_after_enable", 32'(underflow), 32'd1);
        w = words[105];
        cyc(200, 48, w[2:0], 1'b1, 0);

        // Reset mid-frame with the FIFO non-empty.
        reset = 1'b1;
        cyc(201, 48, 3'd0, 1'b0, 0);
        check("midreset_underflow", 32'(underflow), 32'd0);
        check("midreset_word_cnt", 32'(word_cnt), 32'd0);
        reset = 1'b0;
        cyc(202, 48, 3'd0, 1'b0, 0);
        cyc(203, 48, 3'd0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
